pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Sits directly downstream of the system PLL and runs on its output clock.
- Synchronises the PLL `locked` flag.
- Holds the core in reset until lock has been stable for a settle period.
- Generates the pixel clock-enable.
- Counts lock-loss events.
- Optionally drives a watchdog reset back into the PLL when lock never arrives.

Parameters:
SETTLE_CYCLES, 1024, cycles locked must stay high before release (>=1)
CE_DIV, 2, clock-enable divide ratio for ce_pix (>=1)
SYNC_STAGES, 2, flops in locked synchroniser (>=2)
LOCK_TIMEOUT, 65535, watchdog: cycles in WAIT_LOCK before PLL reset pulse (>=2)
RST_PULSE, 16, watchdog: width of pll_rst pulse in cycles (>=1)

Ports:
clk_sys  in  1  PLL output clock; sole clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock flag, asynchronous to clk_sys
pll_rst  out  1  active-high reset request to PLL
core_reset  out  1  active-high reset to core logic
ready  out  1  high while sequencer is in RUN
ce_pix  out  1  single-cycle pixel clock-enable
lock_loss_cnt  out  8  saturating count of RUN->lock-lost events

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - synchroniser=0, state=WAIT_LOCK, all counters=0.
  - core_reset=1, ready=0, ce_pix=0, pll_rst=0, lock_loss_cnt=0.
  - Applies immediately, including mid-RUN.
- locked_s is pll_locked after a SYNC_STAGES flop chain. Only locked_s is used internally.
- States: WAIT_LOCK, SETTLE, RUN, PLL_RST. Outputs are Moore-decoded from the state register:
  - core_reset = (state != RUN)
  - ready = (state == RUN)
  - pll_rst = (state == PLL_RST)
- WAIT_LOCK:
  - locked_s=1 -> SETTLE, cnt:=0.
  - Otherwise cnt++.
  - Watchdog only: cnt==LOCK_TIMEOUT-1 -> PLL_RST, cnt:=0.
- SETTLE:
  - locked_s=0 -> WAIT_LOCK, cnt:=0. No loss counted.
  - Else if cnt==SETTLE_CYCLES-1 -> RUN, div:=0.
  - Else cnt++.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- RUN:
  - locked_s=0 -> WAIT_LOCK, cnt:=0, lock_loss_cnt++ (saturates at 255, never wraps).
  - Otherwise div counts 0..CE_DIV-1 and wraps.
- ce_pix is registered:
  - High for one cycle when div==CE_DIV-1 and state is RUN with locked_s=1.
  - First ce_pix pulse falls in the CE_DIV-th cycle of RUN.
  - CE_DIV=1 gives ce_pix=1 every RUN cycle.
  - ce_pix is 0 in every other state and on the transition out of RUN.
- PLL_RST:
  - Stays for RST_PULSE cycles (cnt 0..RST_PULSE-1), then -> WAIT_LOCK, cnt:=0.
  - locked_s is ignored during the pulse.
- Latency: pll_locked rising and held -> ready=1 after SYNC_STAGES+1+SETTLE_CYCLES clk_sys edges.
- Loss-to-reset latency: SYNC_STAGES+1 edges.
- Counter widths are $clog2 of the largest terminal value, with no overflow possible.

Optional Feature:
PLL_LOCK_WATCHDOG_EN
- Defined: PLL_RST state, timeout compare and pll_rst output logic are present, as described above.
- Undefined: PLL_RST state is absent and pll_rst is tied 0. WAIT_LOCK waits indefinitely and cnt is not incremented there. LOCK_TIMEOUT and RST_PULSE are unused.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum typedef seq_state_t {WAIT_LOCK, SETTLE, RUN, PLL_RST}
  - constant LOSS_CNT_W=8
  - constant LOSS_CNT_MAX=255
- One sub-module, sync_bit: a parameterised N-flop single-bit synchroniser with asynchronous active-low reset to 0, used for pll_locked.

Test Plan:
1. SETTLE_CYCLES=8, SYNC_STAGES=2, CE_DIV=2; release rst_n, raise pll_locked -> core_reset falls and ready rises exactly 11 edges later; ce_pix high on RUN cycles 2, 4, 6, ...
2. pll_locked low for 1 cycle at SETTLE cycle 5 -> return to WAIT_LOCK; lock_loss_cnt stays 0; ready arrives 11 edges after pll_locked returns high.
3. Drop pll_locked in RUN -> core_reset=1 and ready=0 exactly 3 edges later; ce_pix=0 from the same cycle; lock_loss_cnt=1.
4. 300 lock/unlock cycles through RUN -> lock_loss_cnt reaches 255 and holds 255.
5. PLL_LOCK_WATCHDOG_EN, LOCK_TIMEOUT=100, RST_PULSE=16, pll_locked held 0 -> pll_rst high for exactly 16 cycles beginning 100 cycles after reset release, repeating with period 116. Without the macro, pll_rst stays 0 forever.
6. Assert rst_n mid-RUN, asynchronously between edges -> core_reset=1, ready=0, ce_pix=0, lock_loss_cnt=0 with no clock edge needed; normal sequence restarts after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared types and constants for the PLL lock sequencer.
//   seq_state_t  : sequencer state encoding
//   LOSS_CNT_W   : width of the lock-loss event counter
//   LOSS_CNT_MAX : saturation value of the lock-loss event counter
//   max3         : elaboration-time helper for sizing counters

package pll_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        PLL_RST   = 2'd3
    } seq_state_t;

    localparam int LOSS_CNT_W   = 8;
    localparam int LOSS_CNT_MAX = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit
// Single-bit N-flop synchroniser for a level signal crossing into clk_sys.
// Ports:
//   clk_sys : destination clock
//   rst_n   : asynchronous active-low reset, clears the chain to 0
//   d       : asynchronous input level
//   q       : synchronised level, STAGES cycles behind d

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Runs on the PLL output clock. Synchronises the PLL lock flag, holds the
// core in reset until lock has been stable for SETTLE_CYCLES, generates the
// pixel clock-enable while running and counts lock-loss events.
// Optional build macro PLL_LOCK_WATCHDOG_EN adds a watchdog that pulses
// pll_rst when lock does not arrive within LOCK_TIMEOUT cycles.
// Ports:
//   clk_sys       : PLL output clock, sole clock
//   rst_n         : asynchronous active-low reset
//   pll_locked    : PLL lock flag, asynchronous to clk_sys
//   pll_rst       : active-high reset request to the PLL
//   core_reset    : active-high reset to core logic (low only in RUN)
//   ready         : high while in RUN
//   ce_pix        : single-cycle pixel clock-enable, one per CE_DIV RUN cycles
//   lock_loss_cnt : saturating count of RUN -> lock-lost events
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | waiting for synchronised lock; watchdog timer runs if built
// SETTLE    | lock seen, counting SETTLE_CYCLES of uninterrupted lock
// RUN       | core released, ce_pix active
// PLL_RST   | watchdog pulse to PLL for RST_PULSE cycles (watchdog build)

module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024,
    parameter int CE_DIV        = 2,
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int RST_PULSE     = 16
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  core_reset,
    output logic                  ready,
    output logic                  ce_pix,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    // One shared counter serves settle, timeout and pulse timing; it is sized
    // for the largest terminal so parameter sets carry between builds unchanged.
    localparam int CNT_MAX = max3(SETTLE_CYCLES, LOCK_TIMEOUT, RST_PULSE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(CE_DIV - 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT = LOSS_CNT_W'(LOSS_CNT_MAX);
`ifdef PLL_LOCK_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PULSE_TC   = CNT_W'(RST_PULSE - 1);
`endif

    logic                  locked_s;
    seq_state_t            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [DIV_W-1:0]      div, div_d;
    logic [LOSS_CNT_W-1:0] loss_d;
    logic                  ce_pix_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_LOCK;
            cnt           <= '0;
            div           <= '0;
            ce_pix        <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            div           <= div_d;
            ce_pix        <= ce_pix_d;
            lock_loss_cnt <= loss_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        div_d   = div;
        loss_d  = lock_loss_cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
`ifdef PLL_LOCK_WATCHDOG_EN
                else if (cnt == TIMEOUT_TC) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
`endif
            end
            SETTLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt == SETTLE_TC) begin
                    state_d = RUN;
                    div_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (lock_loss_cnt != LOSS_SAT) begin
                        loss_d = lock_loss_cnt + LOSS_CNT_W'(1);
                    end
                end else if (div == DIV_TC) begin
                    div_d = '0;
                end else begin
                    div_d = div + DIV_W'(1);
                end
            end
`ifdef PLL_LOCK_WATCHDOG_EN
            PLL_RST: begin
                if (cnt == PULSE_TC) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // Decoded from next-state values so the registered enable lands in
        // the RUN cycle whose divider value is the terminal one; this makes
        // the first pulse fall in RUN cycle CE_DIV and never on RUN exit.
        ce_pix_d = (state_d == RUN) && (div_d == DIV_TC);
    end

    assign core_reset = (state != RUN);
    assign ready      = (state == RUN);
`ifdef PLL_LOCK_WATCHDOG_EN
    assign pll_rst    = (state == PLL_RST);
`else
    assign pll_rst    = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Scoreboard bench for pll_lock_sequencer. Stimulus pushes the expected
// ready / pll_rst transitions (cycle, value, loss count) into queues; a
// negedge monitor pops and compares them as the DUT produces them, and
// checks ce_pix cadence and output decode every cycle.
// Honours PLL_LOCK_WATCHDOG_EN the same way as the design.

module tb_pll_lock_sequencer;

    localparam int SETTLE  = 8;
    localparam int CE_DIV  = 2;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 100;
    localparam int PULSE   = 16;
    localparam int LAT_UP  = SYNC + 1 + SETTLE;
    localparam int LAT_DN  = SYNC + 1;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       ce_pix;
    logic [7:0] lock_loss_cnt;

    pll_lock_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .CE_DIV        (CE_DIV),
        .SYNC_STAGES   (SYNC),
        .LOCK_TIMEOUT  (TIMEOUT),
        .RST_PULSE     (PULSE)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .core_reset    (core_reset),
        .ready         (ready),
        .ce_pix        (ce_pix),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cyc;
        int val;
        int loss;
    } ev_t;

    ev_t rdy_q[$];
    int  prst_q[$];
    int  loss_model = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", tag, obs, exp, $time, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic raise_lock();
        @(negedge clk_sys);
        pll_locked = 1'b1;
        rdy_q.push_back('{cyc + LAT_UP, 1, loss_model});
    endtask

    task automatic drop_lock();
        @(negedge clk_sys);
        pll_locked = 1'b0;
        if (loss_model < 255) loss_model++;
        rdy_q.push_back('{cyc + LAT_DN, 0, loss_model});
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && rdy_q.size() > 0; i++) @(negedge clk_sys);
        check(tag, rdy_q.size(), 0);
    endtask

    // Monitor
    logic prev_rdy  = 1'b0;
    logic prev_prst = 1'b0;
    int   run_cyc   = 0;

    always @(negedge clk_sys) begin
        ev_t ev;
        if (!rst_n) begin
            prev_rdy  = ready;
            prev_prst = pll_rst;
            run_cyc   = 0;
        end else begin
            check("core_reset_decode", core_reset, !ready);
            if (ready) begin
                run_cyc++;
                check("ce_pix_run", ce_pix, (run_cyc % CE_DIV) == 0);
            end else begin
                run_cyc = 0;
                check("ce_pix_idle", ce_pix, 0);
            end
            if (ready !== prev_rdy) begin
                if (rdy_q.size() == 0) begin
                    check("ready_unexpected_edge", ready, prev_rdy);
                end else begin
                    ev = rdy_q.pop_front();
                    check("ready_edge_cycle", cyc, ev.cyc);
                    check("ready_edge_value", ready, ev.val);
                    check("loss_cnt_at_edge", lock_loss_cnt, ev.loss);
                end
                prev_rdy = ready;
            end
            if (pll_rst !== prev_prst) begin
                if (prst_q.size() == 0) begin
                    check("pll_rst_unexpected_edge", pll_rst, prev_prst);
                end else begin
                    check("pll_rst_edge_cycle", cyc, prst_q.pop_front());
                end
                prev_prst = pll_rst;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete (cyc=%0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #1 rst_n = 1'b0;
        #3;
        check("rst_core_reset", core_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_ce_pix", ce_pix, 0);
        check("rst_pll_rst", pll_rst, 0);
        check("rst_loss_cnt", lock_loss_cnt, 0);
        idle(2);
        rst_n = 1'b1;

        // basic lock-up latency and ce_pix cadence
        raise_lock();
        drain("drain_lock_up");
        idle(7);

        // loss in RUN
        drop_lock();
        drain("drain_loss");
        check("loss_cnt_after_first_loss", lock_loss_cnt, 1);

        // one-cycle glitch during SETTLE restarts the settle window
        @(negedge clk_sys);
        pll_locked = 1'b1;
        idle(5);
        pll_locked = 1'b0;
        @(negedge clk_sys);
        pll_locked = 1'b1;
        rdy_q.push_back('{cyc + LAT_UP, 1, loss_model});
        drain("drain_glitch_relock");
        check("loss_cnt_after_glitch", lock_loss_cnt, 1);
        drop_lock();
        drain("drain_loss2");

        // saturation of the loss counter
        for (int i = 0; i < 300; i++) begin
            raise_lock();
            drain("drain_sat_up");
            idle(2);
            drop_lock();
            drain("drain_sat_down");
        end
        check("loss_cnt_saturated", lock_loss_cnt, 255);

        // asynchronous reset mid-RUN
        raise_lock();
        drain("drain_pre_async");
        for (int i = 0; i < 4 && ce_pix !== 1'b1; i++) @(negedge clk_sys);
        check("ce_pix_before_async_rst", ce_pix, 1);
        #2 rst_n = 1'b0;
        pll_locked = 1'b0;
        #1;
        check("async_core_reset", core_reset, 1);
        check("async_ready", ready, 0);
        check("async_ce_pix", ce_pix, 0);
        check("async_loss_cnt", lock_loss_cnt, 0);
        loss_model = 0;
        idle(2);
        rst_n = 1'b1;
        raise_lock();
        drain("drain_after_async");
        idle(3);
        drop_lock();
        drain("drain_after_async_loss");
        check("loss_cnt_after_restart", lock_loss_cnt, 1);

        // watchdog behaviour with lock held low from reset release
        @(negedge clk_sys);
        rst_n = 1'b0;
        pll_locked = 1'b0;
        idle(2);
        rst_n = 1'b1;
`ifdef PLL_LOCK_WATCHDOG_EN
        prst_q.push_back(cyc + TIMEOUT);
        prst_q.push_back(cyc + TIMEOUT + PULSE);
        prst_q.push_back(cyc + 2 * TIMEOUT + PULSE);
        prst_q.push_back(cyc + 2 * (TIMEOUT + PULSE));
        idle(2 * (TIMEOUT + PULSE) + 5);
        check("pll_rst_events_seen", prst_q.size(), 0);
`else
        idle(300);
        check("pll_rst_stays_low", pll_rst, 0);
`endif
        check("no_ready_while_unlocked", ready, 0);

        check("scoreboard_empty", rdy_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
